// File: rtl/pong_game_ctl.sv
// rtl/pong_game_ctl.sv - Pong round sequencer: serve/play/pause/point/over flow, scoring and mode latching.
module pong_game_ctl #(
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int WIN_SCORE    = 9,
  parameter int MISS_L       = 10,
  parameter int MISS_R       = 1014
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        start_btn,
  input  logic        mode_2_sw,
  input  logic        mode_3_sw,
  input  logic [10:0] ball_x_pos,
  output logic        ball_en,
  output logic        ball_rst,
  output logic        serve_dir,
  output logic        mode_2,
  output logic        mode_3,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic        point,
  output logic        game_over,
  output logic        winner,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    POINT = 3'd4,
    OVER  = 3'd5
  } state_t;

  state_t      st_q, st_d;
  logic        vsync_q, start_q;
  logic        frame_tick, start_edge;
  logic        miss_l, miss_r;
  logic [6:0]  frame_cnt, frame_cnt_d;
  logic [3:0]  score_l_d, score_r_d;
  logic        serve_dir_d, mode_2_d, mode_3_d, point_d, winner_d;

  assign frame_tick = vsync & ~vsync_q;
  assign start_edge = start_btn & ~start_q;
  assign miss_l     = ball_x_pos < 11'(MISS_L);
  assign miss_r     = ball_x_pos > 11'(MISS_R);

  assign state    = st_q;
  assign ball_en  = (st_q == PLAY);
  assign ball_rst = (st_q == IDLE) || (st_q == SERVE) || (st_q == OVER);

  always_comb begin
    st_d        = st_q;
    score_l_d   = score_l;
    score_r_d   = score_r;
    serve_dir_d = serve_dir;
    mode_2_d    = mode_2;
    mode_3_d    = mode_3;
    winner_d    = winner;
    point_d     = 1'b0;
    frame_cnt_d = frame_tick ? frame_cnt + 7'd1 : frame_cnt;

    case (st_q)
      IDLE, OVER: begin
        if (start_edge) begin
          mode_2_d    = mode_2_sw;
          mode_3_d    = mode_3_sw;
          score_l_d   = 4'd0;
          score_r_d   = 4'd0;
          winner_d    = 1'b0;
          serve_dir_d = 1'b0;
          st_d        = SERVE;
        end
      end
      SERVE: begin
        if (frame_tick && frame_cnt == 7'(SERVE_FRAMES - 1)) st_d = PLAY;
      end
      PLAY: begin
        // Left miss has priority and a miss always swallows a same-cycle start press.
        if (miss_l) begin
          score_r_d   = score_r + 4'd1;
          serve_dir_d = 1'b1;
          point_d     = 1'b1;
          if (score_r_d == 4'(WIN_SCORE)) begin
            st_d     = OVER;
            winner_d = 1'b1;
          end else begin
            st_d = POINT;
          end
        end else if (miss_r) begin
          score_l_d   = score_l + 4'd1;
          serve_dir_d = 1'b0;
          point_d     = 1'b1;
          if (score_l_d == 4'(WIN_SCORE)) begin
            st_d     = OVER;
            winner_d = 1'b0;
          end else begin
            st_d = POINT;
          end
        end else if (start_edge) begin
          st_d = PAUSE;
        end
      end
      PAUSE: begin
        if (start_edge) st_d = PLAY;
      end
      POINT: begin
        if (frame_tick && frame_cnt == 7'(POINT_FRAMES - 1)) st_d = SERVE;
      end
      default: st_d = IDLE;
    endcase

    if (st_d != st_q) frame_cnt_d = 7'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q      <= IDLE;
      vsync_q   <= 1'b0;
      start_q   <= 1'b0;
      frame_cnt <= 7'd0;
      score_l   <= 4'd0;
      score_r   <= 4'd0;
      serve_dir <= 1'b0;
      mode_2    <= 1'b0;
      mode_3    <= 1'b0;
      point     <= 1'b0;
      winner    <= 1'b0;
      game_over <= 1'b0;
    end else begin
      st_q      <= st_d;
      vsync_q   <= vsync;
      start_q   <= start_btn;
      frame_cnt <= frame_cnt_d;
      score_l   <= score_l_d;
      score_r   <= score_r_d;
      serve_dir <= serve_dir_d;
      mode_2    <= mode_2_d;
      mode_3    <= mode_3_d;
      point     <= point_d;
      winner    <= winner_d;
      game_over <= (st_d == OVER);
    end
  end

endmodule

// File: tb/tb_pong_game_ctl.sv
// tb/tb_pong_game_ctl.sv - Scoreboard bench for pong_game_ctl with directed round sequences.
module tb_pong_game_ctl;

  localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2,
                         S_PAUSE = 3'd3, S_POINT = 3'd4, S_OVER = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vsync = 1'b0;
  logic        start_btn = 1'b0;
  logic        mode_2_sw = 1'b0;
  logic        mode_3_sw = 1'b0;
  logic [10:0] ball_x_pos = 11'd512;
  logic        ball_en, ball_rst, serve_dir, mode_2, mode_3, point, game_over, winner;
  logic [3:0]  score_l, score_r;
  logic [2:0]  state;

  typedef struct {
    string       name;
    logic [17:0] v;
  } exp_t;

  exp_t pt_q[$];
  exp_t snap_q[$];
  logic chk_req = 1'b0;
  logic done = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  pong_game_ctl #(
    .SERVE_FRAMES(2),
    .POINT_FRAMES(2),
    .WIN_SCORE(3),
    .MISS_L(10),
    .MISS_R(1014)
  ) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .start_btn(start_btn),
    .mode_2_sw(mode_2_sw), .mode_3_sw(mode_3_sw), .ball_x_pos(ball_x_pos),
    .ball_en(ball_en), .ball_rst(ball_rst), .serve_dir(serve_dir),
    .mode_2(mode_2), .mode_3(mode_3), .score_l(score_l), .score_r(score_r),
    .point(point), .game_over(game_over), .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  function automatic exp_t e(string name, logic [2:0] st, logic [3:0] sl, logic [3:0] sr,
                             logic sd, logic w, logic m2, logic m3);
    exp_t r;
    logic en, brst, go;
    en   = (st == S_PLAY);
    brst = (st == S_IDLE) || (st == S_SERVE) || (st == S_OVER);
    go   = (st == S_OVER);
    r.name = name;
    r.v    = {st, sl, sr, sd, en, brst, go, w, m2, m3};
    return r;
  endfunction

  // Monitor: pops point records on every point pulse, snapshots on check requests.
  always @(negedge clk) begin
    logic [17:0] act;
    exp_t        x;
    act = {state, score_l, score_r, serve_dir, ball_en, ball_rst, game_over, winner, mode_2, mode_3};
    if (point) begin
      n_cmp++;
      if (pt_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_point actual=%h state=%0d required=no point", act, state);
      end else begin
        x = pt_q.pop_front();
        if (act !== x.v) begin
          n_bad++;
          $display("FAIL %s actual=%h required=%h", x.name, act, x.v);
        end
      end
    end
    if (chk_req) begin
      n_cmp++;
      if (snap_q.size() == 0) begin
        n_bad++;
        $display("FAIL snapshot_underflow actual=%h required=queued entry", act);
      end else begin
        x = snap_q.pop_front();
        if (act !== x.v) begin
          n_bad++;
          $display("FAIL %s actual=%h required=%h", x.name, act, x.v);
        end
      end
    end
    if (done) begin
      n_cmp++;
      if (pt_q.size() != 0) begin
        n_bad++;
        $display("FAIL missing_points actual=%0d left required=0", pt_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic frame();
    vsync = 1'b1;
    cyc(2);
    vsync = 1'b0;
    cyc(2);
  endtask

  task automatic press();
    start_btn = 1'b1;
    cyc(2);
    start_btn = 1'b0;
    cyc(2);
  endtask

  task automatic check(exp_t x);
    snap_q.push_back(x);
    chk_req = 1'b1;
    cyc(1);
    chk_req = 1'b0;
  endtask

  task automatic miss(logic [10:0] x, exp_t ex);
    pt_q.push_back(ex);
    ball_x_pos = x;
    cyc(1);
    ball_x_pos = 11'd512;
    cyc(2);
  endtask

  task automatic hold_x(logic [10:0] x);
    ball_x_pos = x;
    cyc(4);
    ball_x_pos = 11'd512;
    cyc(1);
  endtask

  initial begin
    cyc(3);
    check(e("reset_state", S_IDLE, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    cyc(2);

    mode_3_sw = 1'b1;
    press();
    check(e("serve_entry", S_SERVE, 0, 0, 0, 0, 0, 1));
    frame();
    check(e("serve_one_frame", S_SERVE, 0, 0, 0, 0, 0, 1));
    frame();
    check(e("play_after_two_frames", S_PLAY, 0, 0, 0, 0, 0, 1));
    mode_3_sw = 1'b0;

    press();
    check(e("pause_entry", S_PAUSE, 0, 0, 0, 0, 0, 1));
    hold_x(11'd0);
    check(e("pause_no_miss", S_PAUSE, 0, 0, 0, 0, 0, 1));
    press();
    check(e("resume_play", S_PLAY, 0, 0, 0, 0, 0, 1));

    hold_x(11'd10);
    hold_x(11'd1014);
    check(e("edge_x_no_score", S_PLAY, 0, 0, 0, 0, 0, 1));
    miss(11'd1015, e("right_miss", S_POINT, 1, 0, 0, 0, 0, 1));
    press();
    check(e("start_ignored_point", S_POINT, 1, 0, 0, 0, 0, 1));
    frame();
    check(e("point_one_frame", S_POINT, 1, 0, 0, 0, 0, 1));
    frame();
    check(e("point_to_serve", S_SERVE, 1, 0, 0, 0, 0, 1));
    press();
    check(e("start_ignored_serve", S_SERVE, 1, 0, 0, 0, 0, 1));
    frame();
    frame();

    pt_q.push_back(e("miss_beats_start", S_POINT, 1, 1, 1, 0, 0, 1));
    ball_x_pos = 11'd5;
    start_btn  = 1'b1;
    cyc(1);
    ball_x_pos = 11'd512;
    start_btn  = 1'b0;
    cyc(2);
    check(e("no_pause_after_miss", S_POINT, 1, 1, 1, 0, 0, 1));
    repeat (4) frame();

    miss(11'd9, e("left_miss_2", S_POINT, 1, 2, 1, 0, 0, 1));
    repeat (4) frame();
    miss(11'd9, e("left_win", S_OVER, 1, 3, 1, 1, 0, 1));
    hold_x(11'd0);
    frame();
    check(e("over_holds", S_OVER, 1, 3, 1, 1, 0, 1));

    mode_2_sw = 1'b1;
    press();
    check(e("restart_from_over", S_SERVE, 0, 0, 0, 0, 1, 0));
    frame();
    frame();
    check(e("play_game2", S_PLAY, 0, 0, 0, 0, 1, 0));
    rst = 1'b0;
    check(e("async_reset", S_IDLE, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    cyc(2);

    press();
    frame();
    frame();
    miss(11'd2000, e("right_miss_g3_1", S_POINT, 1, 0, 0, 0, 1, 0));
    repeat (4) frame();
    miss(11'd1015, e("right_miss_g3_2", S_POINT, 2, 0, 0, 0, 1, 0));
    repeat (4) frame();
    miss(11'd1500, e("right_win", S_OVER, 3, 0, 0, 0, 1, 0));
    cyc(3);
    done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
